// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation sequencer.
//   RSA_WIDTH   : default operand/modulus/exponent width
//   rsa_state_e : sequencer state encoding
package rsa_pkg;

    localparam int unsigned RSA_WIDTH = 256;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TR_ISSUE,
        S_TR_WAIT,
        S_BIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_SQR_ISSUE,
        S_SQR_WAIT,
        S_DONE
    } rsa_state_e;

endpackage

// File: rtl/rsa_exp_ctrl.sv
// Sequencer for modular exponentiation o_result = i_a^i_d mod i_n using
// right-to-left square-and-multiply. Drives a Montgomery-transform engine
// (o_tr_* / i_tr_*) and a shared Montgomery-product engine (o_mm_* / i_mm_*)
// through single-cycle start strobes and finished handshakes.
//   i_clk, i_rst      : clock, asynchronous active-low reset
//   i_start           : begin operation (sampled only when idle)
//   i_a, i_d, i_n     : base, exponent, odd modulus
//   o_result          : a^d mod n, valid from o_finished until the next start
//   o_finished        : one-cycle done pulse
//   o_busy            : high from accepted start through the o_finished cycle
//   o_tr_*, i_tr_*    : transform engine interface
//   o_mm_*, i_mm_*    : product engine interface
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished,
    output logic             o_busy,
    output logic             o_tr_start,
    output logic [WIDTH-1:0] o_tr_a,
    output logic [WIDTH-1:0] o_tr_n,
    input  logic [WIDTH-1:0] i_tr_a_mont,
    input  logic             i_tr_finished,
    output logic             o_mm_start,
    output logic [WIDTH-1:0] o_mm_a,
    output logic [WIDTH-1:0] o_mm_b,
    output logic [WIDTH-1:0] o_mm_n,
    input  logic [WIDTH-1:0] i_mm_result,
    input  logic             i_mm_finished
);

    localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    rsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            d_q      <= '0;
            n_q      <= '0;
            m_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            d_q      <= d_d;
            n_q      <= n_d;
            m_q      <= m_d;
            t_q      <= t_d;
            result_q <= result_d;
            k_q      <= k_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        d_d      = d_q;
        n_d      = n_q;
        m_d      = m_q;
        t_d      = t_q;
        result_d = result_q;
        k_d      = k_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    d_d     = i_d;
                    n_d     = i_n;
                    m_d     = WIDTH'(1);
                    k_d     = '0;
                    state_d = S_TR_ISSUE;
                end
            end
            S_TR_ISSUE: state_d = S_TR_WAIT;
            S_TR_WAIT: begin
                if (i_tr_finished) begin
                    t_d     = i_tr_a_mont;
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                if (d_q[k_q]) begin
                    state_d = S_MUL_ISSUE;
                end else if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SQR_ISSUE;
                end
            end
            S_MUL_ISSUE: state_d = S_MUL_WAIT;
            S_MUL_WAIT: begin
                // m stays in the normal domain: MM(m, t_mont) = m * t.
                if (i_mm_finished) begin
                    m_d     = i_mm_result;
                    state_d = (k_q == K_LAST) ? S_DONE : S_SQR_ISSUE;
                end
            end
            S_SQR_ISSUE: state_d = S_SQR_WAIT;
            S_SQR_WAIT: begin
                if (i_mm_finished) begin
                    t_d     = i_mm_result;
                    k_d     = k_q + KW'(1);
                    state_d = S_BIT;
                end
            end
            S_DONE: begin
                result_d = m_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_finished = (state_q == S_DONE);
    assign o_tr_start = (state_q == S_TR_ISSUE);
    assign o_mm_start = (state_q == S_MUL_ISSUE) || (state_q == S_SQR_ISSUE);
    assign o_tr_a     = a_q;
    assign o_tr_n     = n_q;
    assign o_mm_n     = n_q;
    assign o_mm_a     = ((state_q == S_SQR_ISSUE) || (state_q == S_SQR_WAIT)) ? t_q : m_q;
    assign o_mm_b     = t_q;
    // Present m directly in the done cycle so the result is valid with o_finished.
    assign o_result   = (state_q == S_DONE) ? m_q : result_q;

endmodule

// File: doc/rsa_exp_ctrl.md
Name: rsa_exp_ctrl

Overview:
- Sequencer for RSA modular exponentiation: computes o_result = i_a^i_d mod i_n.
- Drives one Montgomery-transform engine and one shared Montgomery-product engine through start/finished handshakes.
- Uses right-to-left square-and-multiply over WIDTH exponent bits.
- Sits between the RSA top-level I/O wrapper and the two arithmetic engines; holds no arithmetic itself beyond registers and muxing.

Parameters:
WIDTH, 256, operand/modulus/exponent width; Montgomery radix is 2^WIDTH

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_start  in  1  begin exponentiation; sampled only in S_IDLE
i_a  in  WIDTH  base, required a < n
i_d  in  WIDTH  exponent
i_n  in  WIDTH  modulus, required odd and > 1
o_result  out  WIDTH  a^d mod n, valid from o_finished until next accepted start
o_finished  out  1  one-cycle done pulse
o_busy  out  1  high from accepted start until o_finished cycle inclusive
o_tr_start  out  1  transform engine start pulse
o_tr_a  out  WIDTH  transform operand (latched a)
o_tr_n  out  WIDTH  latched n
i_tr_a_mont  in  WIDTH  a*2^WIDTH mod n
i_tr_finished  in  1  transform done
o_mm_start  out  1  product engine start pulse
o_mm_a  out  WIDTH  product operand A
o_mm_b  out  WIDTH  product operand B
o_mm_n  out  WIDTH  latched n
i_mm_result  in  WIDTH  A*B*2^-WIDTH mod n
i_mm_finished  in  1  product done

Behaviour:
- Reset (i_rst=0, asynchronous): state=S_IDLE, all outputs 0, internal m/t/d/n/a/bit counter cleared. Reset mid-operation aborts immediately; no strobe is pending after release; engines are reset by the same i_rst.
- S_IDLE: i_start=1 latches a, d, n; sets m=1 and bit index k=0; goes to S_TR_ISSUE. i_start in any other state is ignored.
- Every *_ISSUE state lasts exactly one cycle, asserts its start strobe for that cycle only, then moves to the matching *_WAIT state. Operands are stable from ISSUE until finished. Engines assert finished at least 1 cycle after start.
- S_TR_ISSUE / S_TR_WAIT: on i_tr_finished, t <= i_tr_a_mont, then go to S_BIT.
- S_BIT (1 cycle, decision only):
  - if d[k]=1 -> S_MUL_ISSUE;
  - else if k==WIDTH-1 -> S_DONE;
  - else -> S_SQR_ISSUE.
- S_MUL_ISSUE / S_MUL_WAIT: operands A=m, B=t. On i_mm_finished, m <= i_mm_result. Then go to S_DONE if k==WIDTH-1, else S_SQR_ISSUE.
- S_SQR_ISSUE / S_SQR_WAIT: operands A=t, B=t. On i_mm_finished, t <= i_mm_result, k <= k+1, then go to S_BIT.
- The final square is skipped: WIDTH-1 squares total.
- m starts at plain 1, so MM(m, t_mont) keeps m in the normal domain; no inverse transform is needed.
- S_DONE: o_result <= m and o_finished=1 for one cycle, then S_IDLE. o_result is held until the next accepted start (cleared to 0 only by reset).
- Operation count: 1 transform + popcount(d) products + (WIDTH-1) squares.
- Total cycles = sum over operations of (1 + engine latency) + WIDTH S_BIT cycles + 1 done cycle + 1 start cycle.
- finished inputs are ignored outside the matching WAIT state. Simultaneous finished and state exit: capture happens, no double-capture.
- d=0 -> result 1. Product-engine strobes never overlap; at most one engine is active at a time.
- k is $clog2(WIDTH) bits; no wrap, since termination occurs at k==WIDTH-1.

Decomposition:
- Package rsa_pkg: state enum (S_IDLE, S_TR_ISSUE, S_TR_WAIT, S_BIT, S_MUL_ISSUE, S_MUL_WAIT, S_SQR_ISSUE, S_SQR_WAIT, S_DONE); default WIDTH localparam.
- No sub-module required. Engines are instantiated beside this block at the RSA top level.

Test Plan:
- WIDTH=8, behavioural engines with 3-cycle latency; a=5, d=3, n=13 -> o_result=8. Expect 1 o_tr_start and 9 o_mm_start pulses.
- WIDTH=8: a=7, d=0, n=11 -> o_result=1; 0 product ops with operand A=m, 7 squares, o_finished a single pulse.
- WIDTH=16: a=4, d=13, n=497 -> o_result=445. Engine latency randomized 1..20 cycles per op; result unchanged.
- Start pulse while o_busy=1 with different operands -> ignored; first result is 8 (scenario 1 values).
- Reset asserted during S_MUL_WAIT -> o_busy, o_finished, and strobes go to 0 at once. A fresh start after release (a=2, d=5, n=13) -> o_result=6.
- WIDTH=8: a=12, d=255, n=13 -> o_result=12. o_mm_start never asserted in the same cycle as o_tr_start; strobes are 1 cycle wide.
